// File: rtl/rv_pkg.sv
// Shared register-file writeback types and sizing constants.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    typedef logic [AW-1:0] reg_idx_t;

    // One writeback request as presented by a requester.
    typedef struct packed {
        logic            valid;
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-input grant for the single register-file write port.
// Round-robin on contention, or port 1 always first when FIXED_PRIO is set.
module wb_rr_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    logic last_grant;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        gnt_c = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                if (FIXED_PRIO || !last_grant) begin
                    gnt_c = 2'b10;
                end else begin
                    gnt_c = 2'b01;
                end
            end else begin
                gnt_c = req;
            end
        end
    end

    // Remember the winner of the most recent grant; reset favours port 0 next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|gnt_c) begin
            last_grant <= gnt_c[1];
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: arbitrates ALU/load results onto the single register-file
// write port and keeps the busy scoreboard used by issue for hazard stalls.
module regfile_wb_scheduler #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned AW         = 5,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    input  logic [AW-1:0]   chk_rd,
    output logic            hazard,
    input  logic            wb0_valid,
    input  logic [AW-1:0]   wb0_rd,
    input  logic [XLEN-1:0] wb0_data,
    output logic            wb0_ready,
    input  logic            wb1_valid,
    input  logic [AW-1:0]   wb1_rd,
    input  logic [XLEN-1:0] wb1_data,
    output logic            wb1_ready,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_rdData
);

    import rv_pkg::*;

    wb_req_t         req0;
    wb_req_t         req1;
    wb_req_t         sel;
    logic [1:0]      gnt;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    wb_rr_arbiter #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({wb1_valid, wb0_valid}),
        .gnt_c (gnt)
    );

    assign wb0_ready = gnt[0];
    assign wb1_ready = gnt[1];

    // Pack requester inputs and pick the granted one; valid marks a transfer.
    always_comb begin
        req0.valid = wb0_valid;
        req0.rd    = wb0_rd;
        req0.data  = wb0_data;
        req1.valid = wb1_valid;
        req1.rd    = wb1_rd;
        req1.data  = wb1_data;
        sel        = '0;
        if (gnt[1]) begin
            sel = req1;
        end else if (gnt[0]) begin
            sel = req0;
        end
    end

    // Stall signal for decode: any operand or destination still in flight.
    assign hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

    // Scoreboard update: retiring write clears, issue sets (set wins), x0 never busy.
    always_comb begin
        busy_next = busy;
        if (rf_wen) begin
            busy_next[rf_rd] = 1'b0;
        end
        if (issue_valid) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Registered write port; a transfer to x0 is accepted but never writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen    <= 1'b0;
            rf_rd     <= '0;
            rf_rdData <= '0;
        end else begin
            rf_wen <= sel.valid && (sel.rd != '0);
            if (sel.valid) begin
                rf_rd     <= sel.rd;
                rf_rdData <= sel.data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus a random
// issue/writeback stream checked against a scoreboard-level reference model.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
    logic        hazard;
    logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic [4:0]  wb0_rd = '0, wb1_rd = '0;
    logic [31:0] wb0_data = '0, wb1_data = '0;
    logic        wb0_ready, wb1_ready;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rdData;

    // Second instance with fixed priority, own requester inputs
    logic        f_wb0_valid = 1'b0, f_wb1_valid = 1'b0;
    logic [4:0]  f_wb0_rd = 5'd2, f_wb1_rd = 5'd6;
    logic [31:0] f_wb0_data = 32'h0000_0A0A, f_wb1_data = 32'h0000_B1B1;
    logic        f_hazard, f_wb0_ready, f_wb1_ready, f_rf_wen;
    logic [4:0]  f_rf_rd;
    logic [31:0] f_rf_rdData;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_busy [32];
    bit          m_lg;
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.XLEN(32), .NREG(32), .AW(5), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rdData(rf_rdData)
    );

    regfile_wb_scheduler #(.XLEN(32), .NREG(32), .AW(5), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .issue_valid(1'b0), .issue_rd(5'd0),
        .chk_rs1(5'd0), .chk_rs2(5'd0), .chk_rd(5'd0), .hazard(f_hazard),
        .wb0_valid(f_wb0_valid), .wb0_rd(f_wb0_rd), .wb0_data(f_wb0_data), .wb0_ready(f_wb0_ready),
        .wb1_valid(f_wb1_valid), .wb1_rd(f_wb1_rd), .wb1_data(f_wb1_data), .wb1_ready(f_wb1_ready),
        .rf_wen(f_rf_wen), .rf_rd(f_rf_rd), .rf_rdData(f_rf_rdData)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_lg   = 1'b1;
        m_wen  = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    // One clock cycle with inputs already driven at the preceding negedge.
    task automatic cycle(input string tag, output bit g0, output bit g1);
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (wb0_valid && wb1_valid) begin
            if (m_lg) g0 = 1'b1; else g1 = 1'b1;
        end else begin
            g0 = wb0_valid;
            g1 = wb1_valid;
        end
        chk({tag, ".rdy0"}, wb0_ready, g0);
        chk({tag, ".rdy1"}, wb1_ready, g1);
        chk({tag, ".haz"}, hazard, m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd]);
        @(posedge clk);
        if (m_wen) m_busy[m_rd] = 1'b0;
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        if (g0 || g1) begin
            m_lg   = g1;
            m_rd   = g1 ? wb1_rd : wb0_rd;
            m_data = g1 ? wb1_data : wb0_data;
            m_wen  = (m_rd != 0);
        end else begin
            m_wen = 1'b0;
        end
        #1;
        chk({tag, ".wen"}, rf_wen, m_wen);
        if (m_wen) begin
            chk({tag, ".rd"}, rf_rd, m_rd);
            chk({tag, ".data"}, rf_rdData, m_data);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        wb0_valid   = 1'b0;
        wb1_valid   = 1'b0;
    endtask

    initial begin
        bit g0, g1;
        logic [4:0]  q0_rd[$], q1_rd[$];
        logic [31:0] q0_dat[$], q1_dat[$];
        logic [4:0]  rd_seq[4];
        logic [4:0]  exp_seq[4];
        int budget;

        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fixed priority: port 1 wins while it requests, then port 0
        f_wb0_valid = 1'b1;
        f_wb1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp.both.rdy0", f_wb0_ready, 1'b0);
            chk("fp.both.rdy1", f_wb1_ready, 1'b1);
            @(negedge clk);
        end
        chk("fp.wrd", f_rf_rd, 5'd6);
        f_wb1_valid = 1'b0;
        #1;
        chk("fp.solo.rdy0", f_wb0_ready, 1'b1);
        chk("fp.solo.rdy1", f_wb1_ready, 1'b0);
        @(negedge clk);
        f_wb0_valid = 1'b0;
        chk("fp.wrd0", f_rf_rd, 5'd2);

        // Single ALU write to x5
        issue_valid = 1'b1; issue_rd = 5'd5; chk_rs1 = 5'd5;
        cycle("alu.issue", g0, g1);
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
        cycle("alu.xfer", g0, g1);
        chk("alu.haz_busy", hazard, 1'b1);
        wb0_valid = 1'b0;
        cycle("alu.commit", g0, g1);
        chk("alu.commit.rd", rf_rd, 5'd5);
        chk("alu.haz_clear", hazard, 1'b0);

        // Reset mid-cycle with a write in flight and requests pending
        issue_valid = 1'b1; issue_rd = 5'd9;
        cycle("rst.issue", g0, g1);
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h0000_0099;
        cycle("rst.xfer", g0, g1);
        chk("rst.pre_wen", rf_wen, 1'b1);
        wb1_valid = 1'b1; wb1_rd = 5'd10;
        #2 rst = 1'b1;
        #1;
        chk("rst.wen", rf_wen, 1'b0);
        chk("rst.rdy0", wb0_ready, 1'b0);
        chk("rst.rdy1", wb1_ready, 1'b0);
        for (int i = 0; i < 32; i++) begin
            chk_rs1 = 5'(i); chk_rs2 = 5'(i); chk_rd = 5'(i);
            #1 chk("rst.haz", hazard, 1'b0);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;

        // Round-robin contention on x3/x4
        issue_valid = 1'b1; issue_rd = 5'd3;
        cycle("rr.issue3", g0, g1);
        issue_rd = 5'd4;
        cycle("rr.issue4", g0, g1);
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h3333_0000;
        wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h4444_0000;
        exp_seq[0] = 5'd3; exp_seq[1] = 5'd4; exp_seq[2] = 5'd3; exp_seq[3] = 5'd4;
        for (int i = 0; i < 4; i++) begin
            cycle("rr.both", g0, g1);
            chk("rr.grant0", 32'(g0), 32'((i % 2) == 0));
            rd_seq[i] = rf_rd;
            wb0_data = wb0_data + 1;
            wb1_data = wb1_data + 1;
        end
        for (int i = 0; i < 4; i++) chk("rr.rdseq", rd_seq[i], exp_seq[i]);
        idle_inputs();
        cycle("rr.drain", g0, g1);

        // x0: accepted, no write, never busy
        issue_valid = 1'b1; issue_rd = 5'd0; chk_rs2 = 5'd0;
        cycle("x0.issue", g0, g1);
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd0; wb0_data = 32'h0000_1234;
        cycle("x0.xfer", g0, g1);
        chk("x0.rdy", 32'(g0), 32'd1);
        chk("x0.wen", rf_wen, 1'b0);
        chk("x0.haz", hazard, 1'b0);
        wb0_valid = 1'b0;

        // Set and clear of x7 on the same edge: set wins
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle("col.issue", g0, g1);
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h0000_0777;
        cycle("col.xfer", g0, g1);
        wb0_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        cycle("col.both", g0, g1);
        issue_valid = 1'b0; chk_rd = 5'd7;
        #1 chk("col.haz", hazard, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random issue/writeback traffic
        for (int n = 0; n < 600; n++) begin
            chk_rs1 = 5'($urandom_range(0, 31));
            chk_rs2 = 5'($urandom_range(0, 31));
            chk_rd  = 5'($urandom_range(0, 31));
            issue_valid = !(m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd])
                          && ($urandom_range(0, 2) != 0);
            issue_rd = chk_rd;
            wb0_valid = (q0_rd.size() > 0);
            wb1_valid = (q1_rd.size() > 0);
            wb0_rd   = wb0_valid ? q0_rd[0]  : 5'($urandom);
            wb0_data = wb0_valid ? q0_dat[0] : $urandom;
            wb1_rd   = wb1_valid ? q1_rd[0]  : 5'($urandom);
            wb1_data = wb1_valid ? q1_dat[0] : $urandom;
            cycle("rnd", g0, g1);
            if (g0) begin void'(q0_rd.pop_front()); void'(q0_dat.pop_front()); end
            if (g1) begin void'(q1_rd.pop_front()); void'(q1_dat.pop_front()); end
            if (issue_valid) begin
                if ($urandom_range(0, 1) == 0) begin
                    q0_rd.push_back(issue_rd); q0_dat.push_back($urandom);
                end else begin
                    q1_rd.push_back(issue_rd); q1_dat.push_back($urandom);
                end
            end
        end

        // Drain outstanding writebacks within a bounded number of cycles
        issue_valid = 1'b0;
        budget = 100;
        while ((q0_rd.size() + q1_rd.size()) > 0 && budget > 0) begin
            wb0_valid = (q0_rd.size() > 0);
            wb1_valid = (q1_rd.size() > 0);
            if (wb0_valid) begin wb0_rd = q0_rd[0]; wb0_data = q0_dat[0]; end
            if (wb1_valid) begin wb1_rd = q1_rd[0]; wb1_data = q1_dat[0]; end
            cycle("drain", g0, g1);
            if (g0) begin void'(q0_rd.pop_front()); void'(q0_dat.pop_front()); end
            if (g1) begin void'(q1_rd.pop_front()); void'(q1_dat.pop_front()); end
            budget--;
        end
        chk("drain.left", 32'(q0_rd.size() + q1_rd.size()), 32'd0);
        idle_inputs();
        cycle("final", g0, g1);
        for (int i = 0; i < 32; i++) begin
            chk_rs1 = 5'(i); chk_rs2 = 5'(i); chk_rd = 5'(i);
            #1 chk("final.haz", hazard, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single register-file write port between two writeback requesters: port 0 is the ALU result, port 1 is the load result.
- Tracks outstanding destination registers in a busy scoreboard, so issue logic can stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file. The register file has registered reads and one write port, and writes to x0 are discarded.

Parameters:
- XLEN, 32, data width of writeback values.
- NREG, 32, number of architectural registers.
- AW, 5, register index width; must equal clog2(NREG).
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 1 (load) always wins.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  instruction with a destination is issued this cycle.
- issue_rd  in  AW  destination of the issued instruction.
- chk_rs1  in  AW  source 1 index of the instruction in decode.
- chk_rs2  in  AW  source 2 index of the instruction in decode.
- chk_rd  in  AW  destination index of the instruction in decode.
- hazard  out  1  combinational: busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd].
- wb0_valid  in  1  ALU writeback request.
- wb0_rd  in  AW  ALU destination.
- wb0_data  in  XLEN  ALU result.
- wb0_ready  out  1  combinational grant to port 0.
- wb1_valid  in  1  load writeback request.
- wb1_rd  in  AW  load destination.
- wb1_data  in  XLEN  load result.
- wb1_ready  out  1  combinational grant to port 1.
- rf_wen  out  1  registered write enable to the register file.
- rf_rd  out  AW  registered write index.
- rf_rdData  out  XLEN  registered write data.

Behaviour:
- Reset (async, rst=1):
  - busy all 0, last_grant = 1, rf_wen = 0, rf_rd = 0, rf_rdData = 0.
  - wb0_ready and wb1_ready are 0 while rst is asserted.
- Scoreboard:
  - busy[0] is hard-wired 0; issue or writeback to x0 never sets it.
  - Set: at the edge where issue_valid=1 and issue_rd!=0.
  - Clear: at the edge ending a cycle with rf_wen=1, bit rf_rd. The register file commits at that same edge, so a read launched at the next edge returns the new value.
  - Set and clear of the same index at the same edge: set wins.
- Arbitration, combinational, same cycle:
  - Only one valid: that port is granted.
  - Both valid, FIXED_PRIO=0: grant the port opposite last_grant. last_grant updates to the granted port at each edge where a grant occurs.
  - Both valid, FIXED_PRIO=1: port 1 granted; port 0 waits.
  - Exactly one ready high per cycle at most; ready never asserts without the matching valid.
  - Transfer = valid & ready.
- Handshake:
  - A requester holds valid, rd and data stable until ready. Valid may not drop without a transfer (bench assertion).
- Write pipeline:
  - On a transfer, rf_wen/rf_rd/rf_rdData are loaded from the granted port at the next edge; otherwise rf_wen=0 and rd/data hold.
  - Latency: transfer in cycle N → rf_wen=1 in N+1 → register committed and busy cleared at end of N+1. Throughput is one write per cycle.
  - A transfer with rd=0 is accepted (ready asserted) but produces rf_wen=0. There is no scoreboard effect.
- Hazard: issue logic must hold issue_valid low while hazard=1. Issue to an already-busy rd is illegal (assertion, no recovery).
- Reset mid-operation: in-flight rf_wen is dropped, all busy bits cleared, and requesters' pending data is lost. The pipeline is flushed by the same reset.

Decomposition:
- Shared package rv_pkg: XLEN, NREG, AW constants; typedef reg_idx_t (logic [AW-1:0]); typedef wb_req_t struct {valid, rd, data}.
- One sub-module: wb_rr_arbiter (2-input round-robin/fixed-priority grant with last_grant flop). Scoreboard and write register stay in the top module.

Test Plan:
- Reset then idle: rst pulse mid-cycle → rf_wen=0, hazard=0 for all chk indices, both readies 0 during reset.
- Single ALU write: issue rd=5, next cycle wb0 {rd=5, data=0xDEADBEEF} → wb0_ready same cycle, next cycle rf_wen=1/rf_rd=5/rf_rdData=0xDEADBEEF, hazard(chk_rs1=5) drops after that edge.
- Contention, FIXED_PRIO=0: both valid for 4 cycles with rd=3 and rd=4 → grants alternate 0,1,0,1 starting with port 0 after reset; rf_rd sequence 3,4,3,4 (requesters re-present after each grant).
- Contention, FIXED_PRIO=1: both valid → port 1 granted every cycle while wb1_valid=1; port 0 granted in first cycle wb1_valid=0.
- x0 handling: issue rd=0, wb0 rd=0 data=0x1234 → wb0_ready=1, rf_wen stays 0, hazard(chk_rs2=0)=0 throughout.
- Set/clear collision: rf_wen=1 for rd=7 in same cycle as issue_valid rd=7 → busy[7]=1 afterward, hazard(chk_rd=7)=1.
